// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/
// execute/memory/write-back and decodes every datapath control from the state.
module multicycle_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic [2:0] alu_op_o,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       i_or_d_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_source_o,
  output logic [3:0] state_o,
  output logic       instr_retired_o,
  output logic       illegal_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB_R  = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB_I  = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_LUI  = 3'b110;
  localparam logic [2:0] ALU_FUNC = 3'b111;
  localparam logic [2:0] ALU_SUB  = 3'b001;

  state_t state, state_nxt;
  logic   illegal_q;
  // lw/sw direction is captured in DECODE so MEM_ADDR never looks at opcode_i
  logic   is_store_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      illegal_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == S_TRAP) illegal_q <= 1'b1;
      if (state == S_DECODE) is_store_q <= (opcode_i == OP_SW);
    end
  end

  always_comb begin
    state_nxt       = state;
    alu_op_o        = ALU_ADD;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    i_or_d_o        = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    pc_source_o     = 2'b00;
    instr_retired_o = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        if (mem_ready_i) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_LW, OP_SW:           state_nxt = S_MEM_ADDR;
          OP_RTYPE:               state_nxt = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI: state_nxt = S_EXEC_I;
          OP_BEQ:                 state_nxt = S_BRANCH;
          OP_J:                   state_nxt = S_JUMP;
          default:                state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_nxt   = is_store_q ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        i_or_d_o   = 1'b1;
        if (mem_ready_i) state_nxt = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_o     = 1'b1;
        mem_to_reg_o    = 1'b1;
        instr_retired_o = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        i_or_d_o    = 1'b1;
        if (mem_ready_i) begin
          instr_retired_o = 1'b1;
          state_nxt       = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNC;
        state_nxt   = S_ALU_WB_R;
      end
      S_ALU_WB_R: begin
        reg_write_o     = 1'b1;
        reg_dst_o       = 1'b1;
        instr_retired_o = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        case (opcode_i)
          OP_ORI:  alu_op_o = ALU_OR;
          OP_LUI:  alu_op_o = ALU_LUI;
          default: alu_op_o = ALU_ADD;
        endcase
        state_nxt = S_ALU_WB_I;
      end
      S_ALU_WB_I: begin
        reg_write_o     = 1'b1;
        instr_retired_o = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_source_o     = 2'b01;
        instr_retired_o = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_JUMP: begin
        pc_write_o      = 1'b1;
        pc_source_o     = 2'b10;
        instr_retired_o = 1'b1;
        state_nxt       = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign state_o   = state;
  assign illegal_o = illegal_q;

endmodule
